white_balance_coef_calc: RTL and testbench

//  Consumer of wb_ctrl_if: turns CSR control (mode/cal_stb/man_*) into the three per-channel gains applied by
//  the downstream white balance multiplier. Taps the RGB pixel stream (no backpressure). In auto mode, one
//  cal_stb runs one gray-world calibration: accumulate one full frame, gain = sumG/sumX. Returns cur_coef.

---
 rtl/white_balance_coef_calc_pkg.sv | 22 ++
 rtl/wb_ctrl_if.sv | 12 +
 rtl/white_balance_coef_calc_div.sv | 76 +++++++
 rtl/white_balance_coef_calc.sv | 161 ++++++++++++++++
 tb/tb_white_balance_coef_calc.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/white_balance_coef_calc_pkg.sv
// Shared types and constants for the white balance coefficient calculator.
package white_balance_coef_calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ACCUM,
        ST_DIV_R,
        ST_DIV_B,
        ST_DONE
    } wb_state_e;

    localparam logic [1:0] WB_MODE_BYPASS = 2'd0;
    localparam logic [1:0] WB_MODE_MANUAL = 2'd1;
    localparam logic [1:0] WB_MODE_AUTO   = 2'd2;

    localparam logic [1:0] WB_CH_R      = 2'd0;
    localparam logic [1:0] WB_CH_G      = 2'd1;
    localparam logic [1:0] WB_CH_B      = 2'd2;
    localparam logic [1:0] WB_CH_STATUS = 2'd3;

endpackage

// File: rtl/wb_ctrl_if.sv
// CSR-side control bundle for the white balance block; the block is the slave.
interface wb_ctrl_if;
    logic [1:0]  mode;
    logic        cal_stb;
    logic [1:0]  man_sel;
    logic [31:0] man_coef;
    logic        man_lock;
    logic [31:0] cur_coef;

    modport master (output mode, cal_stb, man_sel, man_coef, man_lock, input cur_coef);
    modport slave  (input mode, cal_stb, man_sel, man_coef, man_lock, output cur_coef);
endinterface

// File: rtl/white_balance_coef_calc_div.sv
// Restoring unsigned divider, one quotient bit per cycle; saturates the quotient
// to all-ones on overflow or a zero divisor.
module wb_seq_div #(
    parameter int DIVD_W = 42,
    parameter int DIVS_W = 32,
    parameter int Q_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DIVD_W-1:0] dividend_i,
    input  logic [DIVS_W-1:0] divisor_i,
    output logic              done_o,
    output logic [Q_W-1:0]    quotient_o
);
    localparam int W     = DIVS_W + Q_W;
    localparam int CNT_W = $clog2(Q_W);

    logic [W-1:0]     rem_q;
    logic [W-1:0]     dsh_q;
    logic [Q_W-1:0]   quot_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             done_q;

    logic [W-1:0] dvd_ext;
    logic [W-1:0] dvs_full;
    logic         sat;

    assign dvd_ext  = W'(dividend_i);
    assign dvs_full = {divisor_i, {Q_W{1'b0}}};
    // Anything not below divisor<<Q_W cannot fit in Q_W quotient bits.
    assign sat      = (divisor_i == '0) || (dvd_ext >= dvs_full);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                if (sat) begin
                    quot_q <= '1;
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    rem_q  <= dvd_ext;
                    dsh_q  <= dvs_full >> 1;
                    quot_q <= '0;
                    cnt_q  <= CNT_W'(Q_W - 1);
                    run_q  <= 1'b1;
                end
            end else if (run_q) begin
                if (rem_q >= dsh_q) begin
                    rem_q  <= rem_q - dsh_q;
                    quot_q <= {quot_q[Q_W-2:0], 1'b1};
                end else begin
                    quot_q <= {quot_q[Q_W-2:0], 1'b0};
                end
                dsh_q <= dsh_q >> 1;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quot_q;
endmodule

// File: rtl/white_balance_coef_calc.sv
// Turns CSR control into the applied R/G/B white balance gains; auto mode runs a
// one-frame gray-world calibration on the tapped pixel stream.
module white_balance_coef_calc
    import white_balance_coef_calc_pkg::*;
#(
    parameter int PX_W       = 10,
    parameter int FRAME_PX_W = 22,
    parameter int COEF_W     = 16,
    parameter int FRAC_W     = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              px_valid_i,
    input  logic              px_sof_i,
    input  logic [3*PX_W-1:0] px_data_i,
    wb_ctrl_if.slave          wb_ctrl_i,
    output logic [COEF_W-1:0] coef_r_o,
    output logic [COEF_W-1:0] coef_g_o,
    output logic [COEF_W-1:0] coef_b_o,
    output logic              coef_upd_o,
    output logic              busy_o
);
    localparam int SUM_W = PX_W + FRAME_PX_W;
    localparam logic [COEF_W-1:0] ONE = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC_W;

    wb_state_e                    state_q;
    logic [2:0][SUM_W-1:0]        sum_q;
    logic [2:0][SUM_W-1:0]        sum_add;
    logic [2:0][SUM_W-1:0]        px_ext;
    logic [2:0][COEF_W-1:0]       pend;
    logic [2:0][COEF_W-1:0]       applied;
    logic [COEF_W-1:0]            q_r_q;
    logic                         div_start_q;
    logic                         coef_upd_q;
    logic                         div_done;
    logic [COEF_W-1:0]            div_quot;
    logic [SUM_W-1:0]             div_divisor;
    logic [31:0]                  cur_coef;
    logic                         unused_man_coef_hi;

    logic       sof;
    logic       load;
    logic [1:0] mode;
    logic [1:0] man_sel;

    assign sof     = px_valid_i & px_sof_i;
    assign load    = sof & ~wb_ctrl_i.man_lock;
    assign mode    = wb_ctrl_i.mode;
    assign man_sel = wb_ctrl_i.man_sel;
    assign busy_o  = (state_q != ST_IDLE);
    assign unused_man_coef_hi = ^wb_ctrl_i.man_coef[31:COEF_W];

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [SUM_W:0]      wide;
        logic [COEF_W-1:0]   pend_q;
        logic [COEF_W-1:0]   applied_q;
        logic [COEF_W-1:0]   auto_val;

        // Channel 0 is R, which sits in the top bits of the pixel word.
        assign px_ext[gi]  = SUM_W'(px_data_i[(2-gi)*PX_W +: PX_W]);
        assign wide        = {1'b0, sum_q[gi]} + {1'b0, px_ext[gi]};
        assign sum_add[gi] = wide[SUM_W] ? '1 : wide[SUM_W-1:0];
        assign auto_val    = (2'(gi) == WB_CH_R) ? q_r_q :
                             (2'(gi) == WB_CH_B) ? div_quot : ONE;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pend_q    <= ONE;
                applied_q <= ONE;
            end else begin
                if (load) begin
                    applied_q <= pend_q;
                end
                case (mode)
                    WB_MODE_MANUAL: if (man_sel == 2'(gi)) pend_q <= wb_ctrl_i.man_coef[COEF_W-1:0];
                    WB_MODE_AUTO:   if (state_q == ST_DONE) pend_q <= auto_val;
                    default:        pend_q <= ONE;
                endcase
            end
        end

        assign pend[gi]    = pend_q;
        assign applied[gi] = applied_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            coef_upd_q <= 1'b0;
        end else begin
            coef_upd_q <= load && (pend != applied);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            q_r_q       <= '0;
            div_start_q <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            if (state_q != ST_IDLE && mode != WB_MODE_AUTO) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:  if (wb_ctrl_i.cal_stb && mode == WB_MODE_AUTO) state_q <= ST_ARMED;
                    ST_ARMED: if (sof) begin
                        sum_q   <= px_ext;
                        state_q <= ST_ACCUM;
                    end
                    ST_ACCUM: if (sof) begin
                        div_start_q <= 1'b1;
                        state_q     <= ST_DIV_R;
                    end else if (px_valid_i) begin
                        sum_q <= sum_add;
                    end
                    ST_DIV_R: if (div_done) begin
                        q_r_q       <= div_quot;
                        div_start_q <= 1'b1;
                        state_q     <= ST_DIV_B;
                    end
                    ST_DIV_B: if (div_done) state_q <= ST_DONE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // The divisor mux follows the state; the divider latches it on start.
    assign div_divisor = (state_q == ST_DIV_B) ? sum_q[WB_CH_B] : sum_q[WB_CH_R];

    wb_seq_div #(
        .DIVD_W (SUM_W + FRAC_W),
        .DIVS_W (SUM_W),
        .Q_W    (COEF_W)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_start_q),
        .dividend_i ({sum_q[WB_CH_G], {FRAC_W{1'b0}}}),
        .divisor_i  (div_divisor),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    always_comb begin
        cur_coef = {31'b0, busy_o};
        case (man_sel)
            WB_CH_R: cur_coef = 32'(applied[0]);
            WB_CH_G: cur_coef = 32'(applied[1]);
            WB_CH_B: cur_coef = 32'(applied[2]);
            default: ;
        endcase
    end

    assign wb_ctrl_i.cur_coef = cur_coef;
    assign coef_r_o   = applied[WB_CH_R];
    assign coef_g_o   = applied[WB_CH_G];
    assign coef_b_o   = applied[WB_CH_B];
    assign coef_upd_o = coef_upd_q;
endmodule

// File: tb/tb_white_balance_coef_calc.sv
// Directed bench for white_balance_coef_calc with a frame-level reference model.
module tb_white_balance_coef_calc;
    localparam logic [15:0] ONE     = 16'h0400;
    localparam longint      SUM_MAX = (64'd1 << 32) - 1;

    logic        clk_i;
    logic        rst_i;
    logic        px_valid;
    logic        px_sof;
    logic [29:0] px_data;
    logic [15:0] coef_r;
    logic [15:0] coef_g;
    logic [15:0] coef_b;
    logic        coef_upd;
    logic        busy;

    wb_ctrl_if wb_if();

    white_balance_coef_calc #(
        .PX_W(10), .FRAME_PX_W(22), .COEF_W(16), .FRAC_W(10)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .px_valid_i (px_valid),
        .px_sof_i   (px_sof),
        .px_data_i  (px_data),
        .wb_ctrl_i  (wb_if),
        .coef_r_o   (coef_r),
        .coef_g_o   (coef_g),
        .coef_b_o   (coef_b),
        .coef_upd_o (coef_upd),
        .busy_o     (busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int upd_seen = 0;

    // Reference model: pending/applied sets and a frame-level gray-world calibration.
    logic [15:0] m_pend [3];
    logic [15:0] m_app [3];
    logic        m_upd;
    logic        m_sof;
    logic        m_diff;
    int          m_phase;
    int          m_wait;
    longint      m_sum [3];
    logic [15:0] m_qr;
    logic [15:0] m_qb;

    function automatic logic [15:0] gain(input longint g, input longint x);
        longint q;
        if (x == 0) return 16'hFFFF;
        q = (g << 10) / x;
        return (q > 65535) ? 16'hFFFF : q[15:0];
    endfunction

    function automatic longint comp(input int c);
        return longint'(px_data[(2-c)*10 +: 10]);
    endfunction

    initial begin
        forever begin
            @(posedge clk_i);
            if (rst_i) begin
                for (int c = 0; c < 3; c++) begin
                    m_pend[c] = ONE;
                    m_app[c]  = ONE;
                end
                m_upd = 1'b0; m_phase = 0; m_wait = 0;
            end else begin
                m_sof = px_valid && px_sof;
                m_upd = 1'b0;
                if (m_sof && !wb_if.man_lock) begin
                    m_diff = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        if (m_app[c] != m_pend[c]) m_diff = 1'b1;
                        m_app[c] = m_pend[c];
                    end
                    m_upd = m_diff;
                end
                if (wb_if.mode != 2'd2) begin
                    m_phase = 0;
                    m_wait  = 0;
                end
                if (m_wait > 0) begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) begin
                        m_pend[0] = m_qr; m_pend[1] = ONE; m_pend[2] = m_qb;
                    end
                end
                case (wb_if.mode)
                    2'd1: if (wb_if.man_sel != 2'd3) m_pend[wb_if.man_sel] = wb_if.man_coef[15:0];
                    2'd2: ;
                    default: for (int c = 0; c < 3; c++) m_pend[c] = ONE;
                endcase
                if (wb_if.mode == 2'd2) begin
                    if (m_phase == 0 && m_wait == 0 && wb_if.cal_stb) begin
                        m_phase = 1;
                    end else if (m_phase == 1 && m_sof) begin
                        for (int c = 0; c < 3; c++) m_sum[c] = comp(c);
                        m_phase = 2;
                    end else if (m_phase == 2 && m_sof) begin
                        m_qr = gain(m_sum[1], m_sum[0]);
                        m_qb = gain(m_sum[1], m_sum[2]);
                        m_wait  = 37;
                        m_phase = 0;
                    end else if (m_phase == 2 && px_valid) begin
                        for (int c = 0; c < 3; c++)
                            m_sum[c] = (m_sum[c] + comp(c) > SUM_MAX) ? SUM_MAX : m_sum[c] + comp(c);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        if (!rst_i) begin
            check("coef_r_vs_model", 32'(coef_r), 32'(m_app[0]));
            check("coef_g_vs_model", 32'(coef_g), 32'(m_app[1]));
            check("coef_b_vs_model", 32'(coef_b), 32'(m_app[2]));
            check("coef_upd_vs_model", 32'(coef_upd), 32'(m_upd));
            if (coef_upd) upd_seen++;
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        compare_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic frame_part(input int n, input logic first, input logic [9:0] r,
                              input logic [9:0] g, input logic [9:0] b);
        for (int i = 0; i < n; i++) begin
            px_valid = 1'b1;
            px_sof   = first && (i == 0);
            px_data  = {r, g, b};
            tick();
            px_valid = 1'b0;
            px_sof   = 1'b0;
        end
    endtask

    task automatic frame(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        frame_part(16, 1'b1, r, g, b);
        idle(50);
    endtask

    // One cal_stb, calibration frame, closing frame, then the sof that applies the result.
    task automatic auto_cal(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                            input logic [15:0] er, input logic [15:0] eg, input logic [15:0] eb);
        int upd0;
        upd0 = upd_seen;
        wb_if.cal_stb = 1'b1;
        tick();
        wb_if.cal_stb = 1'b0;
        check("busy_after_cal_stb", 32'(busy), 32'd1);
        frame(r, g, b);
        frame(r, g, b);
        check("busy_done_before_sof", 32'(busy), 32'd0);
        frame_part(1, 1'b1, r, g, b);
        check("auto_coef_r", 32'(coef_r), 32'(er));
        check("auto_coef_g", 32'(coef_g), 32'(eg));
        check("auto_coef_b", 32'(coef_b), 32'(eb));
        check("auto_upd_now", 32'(coef_upd), 32'd1);
        frame_part(15, 1'b0, r, g, b);
        idle(50);
        check("auto_upd_pulses", 32'(upd_seen - upd0), 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; px_valid = 1'b0; px_sof = 1'b0; px_data = '0;
        wb_if.mode = 2'd0; wb_if.cal_stb = 1'b0; wb_if.man_sel = 2'd0;
        wb_if.man_coef = 32'd0; wb_if.man_lock = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        check("rst_coef_r", 32'(coef_r), 32'h400);
        check("rst_coef_g", 32'(coef_g), 32'h400);
        check("rst_coef_b", 32'(coef_b), 32'h400);
        check("rst_upd", 32'(coef_upd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_coef_r", wb_if.cur_coef, 32'h400);
        wb_if.man_sel = 2'd3;
        #1 check("rst_cur_coef_status", wb_if.cur_coef, 32'd0);

        // Auto calibration, balanced-looking 4x4 frame.
        wb_if.mode = 2'd2;
        tick();
        wb_if.cal_stb = 1'b1;
        tick();
        wb_if.cal_stb = 1'b0;
        check("cur_coef_status_busy", wb_if.cur_coef, 32'd1);
        frame(10'd256, 10'd512, 10'd128);
        frame(10'd256, 10'd512, 10'd128);
        frame_part(1, 1'b1, 10'd256, 10'd512, 10'd128);
        check("cal1_coef_r", 32'(coef_r), 32'h0800);
        check("cal1_coef_g", 32'(coef_g), 32'h0400);
        check("cal1_coef_b", 32'(coef_b), 32'h1000);
        frame_part(15, 1'b0, 10'd256, 10'd512, 10'd128);
        idle(50);

        // Manual write mid-frame stays pending until the next sof.
        wb_if.man_sel = 2'd0;
        wb_if.man_coef = 32'h0001_0600;
        frame_part(8, 1'b1, 10'd100, 10'd100, 10'd100);
        wb_if.mode = 2'd1;
        frame_part(8, 1'b0, 10'd100, 10'd100, 10'd100);
        idle(10);
        check("manual_hold_mid_frame", 32'(coef_r), 32'h0800);
        frame_part(1, 1'b1, 10'd100, 10'd100, 10'd100);
        check("manual_coef_r", 32'(coef_r), 32'h0600);
        check("manual_cur_coef", wb_if.cur_coef, 32'h0600);
        frame_part(15, 1'b0, 10'd100, 10'd100, 10'd100);

        // Lock freezes the applied set across a sof.
        wb_if.man_lock = 1'b1;
        wb_if.man_coef = 32'h0000_0700;
        idle(5);
        frame_part(1, 1'b1, 10'd100, 10'd100, 10'd100);
        check("lock_hold_r", 32'(coef_r), 32'h0600);
        frame_part(15, 1'b0, 10'd100, 10'd100, 10'd100);
        wb_if.man_lock = 1'b0;
        idle(5);
        frame_part(1, 1'b1, 10'd100, 10'd100, 10'd100);
        check("unlock_coef_r", 32'(coef_r), 32'h0700);
        frame_part(15, 1'b0, 10'd100, 10'd100, 10'd100);

        // Bypass then auto with R=0 and a B gain beyond range.
        wb_if.mode = 2'd0;
        idle(3);
        frame(10'd5, 10'd5, 10'd5);
        check("bypass_coef_r", 32'(coef_r), 32'h0400);
        wb_if.mode = 2'd2;
        tick();
        auto_cal(10'd0, 10'd1023, 10'd1, 16'hFFFF, 16'h0400, 16'hFFFF);

        // Leaving auto mid-accumulation aborts on the next cycle.
        wb_if.cal_stb = 1'b1;
        tick();
        wb_if.cal_stb = 1'b0;
        frame_part(6, 1'b1, 10'd300, 10'd300, 10'd300);
        check("abort_busy_before", 32'(busy), 32'd1);
        wb_if.mode = 2'd0;
        tick();
        check("abort_busy_after", 32'(busy), 32'd0);
        frame_part(10, 1'b0, 10'd300, 10'd300, 10'd300);
        idle(50);
        frame_part(1, 1'b1, 10'd300, 10'd300, 10'd300);
        check("abort_coef_r", 32'(coef_r), 32'h0400);
        check("abort_coef_g", 32'(coef_g), 32'h0400);
        check("abort_coef_b", 32'(coef_b), 32'h0400);
        frame_part(15, 1'b0, 10'd300, 10'd300, 10'd300);

        // Reset during the R division, then a clean recalibration.
        wb_if.mode = 2'd1;
        wb_if.man_sel = 2'd2;
        wb_if.man_coef = 32'h0000_0123;
        idle(2);
        wb_if.mode = 2'd2;
        frame(10'd7, 10'd7, 10'd7);
        check("pre_rst_coef_b", 32'(coef_b), 32'h0123);
        wb_if.cal_stb = 1'b1;
        tick();
        wb_if.cal_stb = 1'b0;
        frame(10'd256, 10'd512, 10'd128);
        frame_part(1, 1'b1, 10'd256, 10'd512, 10'd128);
        idle(4);
        check("div_busy", 32'(busy), 32'd1);
        rst_i = 1'b1;
        #1;
        check("midrst_coef_b", 32'(coef_b), 32'h0400);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst_i = 1'b0;
        frame_part(15, 1'b0, 10'd256, 10'd512, 10'd128);
        idle(50);
        auto_cal(10'd256, 10'd512, 10'd128, 16'h0800, 16'h0400, 16'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
